disp_scan_driver: RTL and testbench
===================================

Name: disp_scan_driver

Overview:
- Downstream stage of the alarm-clock top level.
- Consumes the two 14-bit segment buses, the AM/PM flag and the alarm speaker level.
- Time-multiplexes the four digits onto one shared 7-segment bus.
- Blinks the display while the alarm rings and turns the speaker level into a square-wave tone for the buzzer.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot; minimum 2.
- BLINK_DIV, 250000: clock cycles per blink half-period while ringing; minimum 1.
- TONE_DIV, 500: clock cycles per tone half-period; minimum 1.
- ZERO_PATTERN, 7'h3F: segment code treated as "0" for hours-tens blanking.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hours_disp  in  14  [13:7] hours-tens segments, [6:0] hours-units segments
- mins_disp  in  14  [13:7] mins-tens segments, [6:0] mins-units segments
- AM_PM_disp  in  1  1 = PM
- SPEAKER_OUT  in  1  alarm ringing level
- seg  out  7  shared segment bus, active-high
- dp  out  1  decimal point, active-high
- dig_en  out  4  digit enables, one-hot active-high
- tone_out  out  1  buzzer square wave

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset, sampled on a rising clk edge, sets:
  - seg=0, dp=0, dig_en=0, tone_out=0
  - idx=0, presc=0
  - shadow registers=0
  - blink counter=0, blink_phase=1
  - tone counter=0
- Reset mid-frame aborts the scan. The next frame starts at idx=0 on the first cycle after reset deasserts.
- Prescaler:
  - presc counts 0..SCAN_DIV-1 then wraps to 0.
  - On wrap, idx advances 0→1→2→3→0.
- Shadow capture:
  - Sources: hours_disp, mins_disp, AM_PM_disp, SPEAKER_OUT (level).
  - Captured into shadow registers on the edge ending any cycle with idx=3 and presc=SCAN_DIV-1.
  - Also captured on the edge ending the first non-reset cycle.
  - Input changes mid-frame are never visible mid-frame (no tearing).
- Output latency: every output is registered. Outputs in cycle t+1 are a function of idx, presc, shadows and blink/tone state in cycle t.
- Digit map:
  - idx0 = mins units [6:0]
  - idx1 = mins tens [13:7]
  - idx2 = hours units [6:0]
  - idx3 = hours tens [13:7]
  - dig_en is one-hot at bit idx.
- Ghost guard: when presc=0, dig_en=0, seg=0 and dp=0 (one blank cycle at the start of every slot).
- dp is 1 only at idx0 with shadow AM_PM=1.
- Leading zero: at idx3, if the shadow hours tens equals ZERO_PATTERN, seg=0. dig_en[3] is still asserted.
- Blink:
  - While shadow speaker=1, the blink counter counts 0..BLINK_DIV-1; blink_phase toggles on wrap.
  - While shadow speaker=0, the counter is held at 0 and blink_phase=1.
  - blink_phase=0 forces seg=0 and dp=0. dig_en keeps scanning.
- Tone:
  - While live SPEAKER_OUT=1, the tone counter counts 0..TONE_DIV-1 and tone_out toggles on wrap. The first toggle comes TONE_DIV cycles after SPEAKER_OUT rises.
  - When SPEAKER_OUT=0, tone_out=0 and the counter is 0 on the next cycle.
  - If SPEAKER_OUT falls on the wrap cycle, clearing wins.
- Simultaneous events: reset overrides everything. The ghost guard overrides blink. Capture and idx wrap occur on the same edge, so slot 0 shows the new shadow.

Test Plan (SCAN_DIV=4, BLINK_DIV=16, TONE_DIV=3):
- Scan order:
  - Stimulus: deassert reset; mins_disp={7'h06,7'h5B}; hours_disp={7'h06,7'h4F}; AM_PM_disp=1.
  - Required: dig_en cycles 0000,0001×3, 0000,0010×3, 0000,0100×3, 0000,1000×3, repeating.
  - Required seg per slot: 5B, 06, 4F, 06. dp=1 only in the 0001 slot.
- Leading-zero blanking:
  - Stimulus: hours_disp[13:7]=7'h3F.
  - Required: during dig_en=1000, seg=0.
  - Stimulus: hours_disp[13:7]=7'h06. Required: seg=06 in that slot.
- No tearing:
  - Stimulus: change mins_disp while idx=1.
  - Required: the remaining slots of the current frame show old values; new values appear from the next idx0 slot.
- Alarm ring:
  - Stimulus: SPEAKER_OUT=1.
  - Required: tone_out first rises 3 cycles after SPEAKER_OUT rises and toggles every 3 cycles.
  - Required: after the next frame capture, seg/dp are blank for alternating 16-cycle windows while dig_en continues.
  - Stimulus: SPEAKER_OUT=0. Required: tone_out=0 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert reset at idx=2, presc=2 while ringing.
  - Required: the next cycle gives all outputs 0.
  - Required after release: dig_en=0000 then 0001 from cycle 2.

Source files
------------

// File: rtl/disp_scan_if.sv
// Bus between the alarm-clock core and the display/buzzer scan driver.
// All signals are plain levels; there is no valid/ready handshake on this bus.
interface disp_scan_if;
  logic [13:0] hours_disp;
  logic [13:0] mins_disp;
  logic        AM_PM_disp;
  logic        SPEAKER_OUT;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_en;
  logic        tone_out;
  logic [1:0]  scan_idx;   // debug view of the digit-slot state

  modport master (
    output hours_disp, mins_disp, AM_PM_disp, SPEAKER_OUT,
    input  seg, dp, dig_en, tone_out, scan_idx
  );

  modport slave (
    input  hours_disp, mins_disp, AM_PM_disp, SPEAKER_OUT,
    output seg, dp, dig_en, tone_out, scan_idx
  );
endinterface

// File: rtl/disp_scan_driver.sv
// Four-digit 7-segment scan driver with frame-synchronous shadow capture,
// leading-zero blanking, alarm blink and buzzer tone generation.
module disp_scan_driver #(
  parameter int         SCAN_DIV     = 1000,
  parameter int         BLINK_DIV    = 250000,
  parameter int         TONE_DIV     = 500,
  parameter logic [6:0] ZERO_PATTERN = 7'h3F
) (
  input  logic       clk,
  input  logic       reset,
  disp_scan_if.slave bus
);
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TW = (TONE_DIV  > 1) ? $clog2(TONE_DIV)  : 1;
  localparam logic [SW-1:0] PRESC_LAST = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);

  typedef enum logic [1:0] {
    SLOT_MIN_U = 2'd0,
    SLOT_MIN_T = 2'd1,
    SLOT_HR_U  = 2'd2,
    SLOT_HR_T  = 2'd3
  } slot_t;

  slot_t         slot_q, slot_d;
  logic [SW-1:0] presc_q;
  logic          primed_q;
  logic [13:0]   sh_hours_q, sh_mins_q;
  logic          sh_ampm_q, sh_spk_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;
  logic [TW-1:0] tone_cnt_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic [3:0]    dig_en_q;
  logic          tone_q;

  logic       presc_wrap, capture, blink_wrap, tone_wrap;
  logic [6:0] digit, seg_d;
  logic       dp_d;
  logic [3:0] dig_en_d;

  assign presc_wrap = (presc_q == PRESC_LAST);
  // The first live cycle also captures so the opening frame never shows reset shadows.
  assign capture    = (presc_wrap && slot_q == SLOT_HR_T) || !primed_q;
  assign blink_wrap = (blink_cnt_q == BLINK_LAST);
  assign tone_wrap  = (tone_cnt_q == TONE_LAST);

  always_comb begin
    slot_d = slot_q;
    if (presc_wrap) begin
      case (slot_q)
        SLOT_MIN_U: slot_d = SLOT_MIN_T;
        SLOT_MIN_T: slot_d = SLOT_HR_U;
        SLOT_HR_U:  slot_d = SLOT_HR_T;
        default:    slot_d = SLOT_MIN_U;
      endcase
    end
  end

  always_comb begin
    digit    = '0;
    seg_d    = '0;
    dp_d     = 1'b0;
    dig_en_d = '0;
    case (slot_q)
      SLOT_MIN_U: digit = sh_mins_q[6:0];
      SLOT_MIN_T: digit = sh_mins_q[13:7];
      SLOT_HR_U:  digit = sh_hours_q[6:0];
      default:    digit = sh_hours_q[13:7];
    endcase
    // presc==0 is the blank guard cycle between digits; it also masks blink.
    if (presc_q != '0) begin
      dig_en_d = 4'b0001 << slot_q;
      seg_d    = digit;
      dp_d     = (slot_q == SLOT_MIN_U) && sh_ampm_q;
      if (slot_q == SLOT_HR_T && digit == ZERO_PATTERN) seg_d = '0;
      if (!blink_phase_q) begin
        seg_d = '0;
        dp_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q        <= SLOT_MIN_U;
      presc_q       <= '0;
      primed_q      <= 1'b0;
      sh_hours_q    <= '0;
      sh_mins_q     <= '0;
      sh_ampm_q     <= 1'b0;
      sh_spk_q      <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      tone_cnt_q    <= '0;
      seg_q         <= '0;
      dp_q          <= 1'b0;
      dig_en_q      <= '0;
      tone_q        <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      presc_q  <= presc_wrap ? '0 : presc_q + 1'b1;
      primed_q <= 1'b1;
      if (capture) begin
        sh_hours_q <= bus.hours_disp;
        sh_mins_q  <= bus.mins_disp;
        sh_ampm_q  <= bus.AM_PM_disp;
        sh_spk_q   <= bus.SPEAKER_OUT;
      end
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      dig_en_q <= dig_en_d;
      if (sh_spk_q) begin
        blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
        if (blink_wrap) blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q   <= '0;
        blink_phase_q <= 1'b1;
      end
      // Tone follows the live speaker level, not the frame shadow.
      if (bus.SPEAKER_OUT) begin
        tone_cnt_q <= tone_wrap ? '0 : tone_cnt_q + 1'b1;
        if (tone_wrap) tone_q <= ~tone_q;
      end else begin
        tone_cnt_q <= '0;
        tone_q     <= 1'b0;
      end
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.dig_en   = dig_en_q;
  assign bus.tone_out = tone_q;
  assign bus.scan_idx = slot_q;
endmodule

// File: tb/tb_disp_scan_driver.sv
// Self-checking bench for disp_scan_driver: directed test-plan scenarios plus
// randomized traffic, checked every cycle against a cycle-count based model.
module tb_disp_scan_driver;
  localparam int S = 4;
  localparam int B = 16;
  localparam int T = 3;
  localparam logic [6:0] ZERO = 7'h3F;

  logic clk = 1'b0;
  logic reset = 1'b1;
  disp_scan_if bus();

  disp_scan_driver #(.SCAN_DIV(S), .BLINK_DIV(B), .TONE_DIV(T), .ZERO_PATTERN(ZERO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: k is the index of the current cycle since reset released;
  // slot and prescaler follow from k by division. brun/trun are the lengths of the
  // current ringing streaks, so blink/tone levels are parities of streak/period.
  int          k = 0;
  int          brun = 0;
  int          trun = 0;
  logic [13:0] m_hours = '0, m_mins = '0;
  logic        m_ampm = 1'b0, m_spk = 1'b0;
  logic [12:0] exp_q[$];   // {tone, dp, dig_en, seg}

  always @(posedge clk) begin
    int         presc, idx;
    logic       phase;
    logic [6:0] digit, e_seg;
    logic       e_dp, e_tone;
    logic [3:0] e_dig;
    if (reset) begin
      k = 0; brun = 0; trun = 0;
      m_hours = '0; m_mins = '0; m_ampm = 1'b0; m_spk = 1'b0;
      exp_q.push_back('0);
    end else begin
      presc = k % S;
      idx   = (k / S) % 4;
      phase = ((brun / B) % 2) == 0;
      case (idx)
        0: digit = m_mins[6:0];
        1: digit = m_mins[13:7];
        2: digit = m_hours[6:0];
        default: digit = m_hours[13:7];
      endcase
      e_seg = '0; e_dp = 1'b0; e_dig = '0;
      if (presc != 0) begin
        e_dig = 4'(1 << idx);
        if (phase && !(idx == 3 && digit == ZERO)) e_seg = digit;
        e_dp = phase && idx == 0 && m_ampm;
      end
      trun   = bus.SPEAKER_OUT ? trun + 1 : 0;
      e_tone = ((trun / T) % 2) == 1;
      brun   = m_spk ? brun + 1 : 0;
      if (k == 0 || (k % (4 * S)) == 4 * S - 1) begin
        m_hours = bus.hours_disp; m_mins = bus.mins_disp;
        m_ampm  = bus.AM_PM_disp; m_spk  = bus.SPEAKER_OUT;
      end
      k++;
      exp_q.push_back({e_tone, e_dp, e_dig, e_seg});
    end
  end

  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("seg",      32'(bus.seg),      32'(e[6:0]));
      check_eq("dig_en",   32'(bus.dig_en),   32'(e[10:7]));
      check_eq("dp",       32'(bus.dp),       32'(e[11]));
      check_eq("tone_out", 32'(bus.tone_out), 32'(e[12]));
      check_eq("scan_idx", 32'(bus.scan_idx), 32'((k / S) % 4));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until the current cycle matches the wanted position within a frame.
  task automatic wait_frame_pos(input int pos, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (k % (4 * S) == pos) begin
        hit = 1'b1;
        break;
      end
      tick(1);
    end
    check_eq(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    bus.mins_disp   = {7'h06, 7'h5B};
    bus.hours_disp  = {7'h06, 7'h4F};
    bus.AM_PM_disp  = 1'b1;
    bus.SPEAKER_OUT = 1'b0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(40);

    bus.hours_disp[13:7] = 7'h3F;
    tick(40);
    bus.hours_disp[13:7] = 7'h06;
    tick(24);

    wait_frame_pos(5, "wait_idx1");
    bus.mins_disp = {7'h66, 7'h7D};
    tick(24);

    bus.SPEAKER_OUT = 1'b1;
    tick(120);
    bus.SPEAKER_OUT = 1'b0;
    tick(24);

    bus.SPEAKER_OUT = 1'b1;
    tick(20);
    wait_frame_pos(10, "wait_idx2_presc2");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(30);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        bus.mins_disp  = 14'($urandom);
        bus.hours_disp = 14'($urandom);
        if ($urandom_range(0, 1) == 0) bus.hours_disp[13:7] = ZERO;
        bus.AM_PM_disp = 1'($urandom);
      end
      if ($urandom_range(0, 24) == 0) bus.SPEAKER_OUT = ~bus.SPEAKER_OUT;
      reset = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
